sa_cache_wb: RTL and testbench
==============================

Name: sa_cache_wb

Overview:
Parametrised N-way set-associative write-back data cache with tree pseudo-LRU replacement, sitting between a core load/store port and the line-based memory interface. It adds three things to the first-generation cache: valid/ready handshakes on the core side, a separate dirty-line writeback channel that completes before refill, and saturating hit/miss counters. It serves one outstanding request at a time. Storage is register-based; no SRAM macro is used.

Parameters:
WAYS, 4, associativity; power of two, >=2
SETS, 256, sets per way; power of two
LINE_BYTES, 64, line size in bytes; power of two, at least DATA_WIDTH/8
DATA_WIDTH, 32, core word width in bits; multiple of 8
ADDR_WIDTH, 32, byte address width
Derived: OFF=log2(LINE_BYTES), IDX=log2(SETS), TAG=ADDR_WIDTH-IDX-OFF, WSEL=OFF-log2(DATA_WIDTH/8), LINE_BITS=8*LINE_BYTES

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  core request valid
o_req_ready  out  1  core request accept; high only in IDLE
i_req_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
i_req_we  in  1  1=write word, 0=read word
i_req_wdata  in  DATA_WIDTH  write data
o_resp_valid  out  1  one-cycle response pulse; no backpressure
o_resp_rdata  out  DATA_WIDTH  read data (reads), written data echoed (writes)
o_resp_hit  out  1  request hit in the cache
o_mem_rd_valid  out  1  refill request valid
i_mem_rd_ready  in  1  refill request accept
o_mem_rd_addr  out  ADDR_WIDTH  line-aligned refill address
i_mem_rd_resp_valid  in  1  refill data valid, single cycle
i_mem_rd_line  in  LINE_BITS  refill line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
o_mem_wb_valid  out  1  dirty-line writeback valid
i_mem_wb_ready  in  1  writeback accept
o_mem_wb_addr  out  ADDR_WIDTH  line-aligned victim address {victim_tag, idx, OFF'b0}
o_mem_wb_line  out  LINE_BITS  victim line data
o_hit_count  out  32  saturating hit counter
o_miss_count  out  32  saturating miss counter

Behaviour:
- Reset (rst_n low, asynchronous): all valid, dirty and PLRU bits clear; FSM goes to IDLE; all outputs 0 except o_req_ready, which is 1 once in IDLE. Data and tag arrays are not reset. Reset asserted mid-operation aborts any pending memory transaction without completing it; dirty data is lost.
- Address split: tag=addr[ADDR_WIDTH-1 -: TAG], idx=addr[OFF+IDX-1 : OFF], word=addr[OFF-1 -: WSEL].
- FSM states: IDLE, LOOKUP, EVICT, REFILL_REQ, REFILL_WAIT, RESP.
- IDLE: o_req_ready=1. When i_req_valid is high, latch addr, we and wdata, then go to LOOKUP.
- LOOKUP: compare the tag against all ways; a way hits when valid && tag match.
  - Hit: a read captures the selected word. A write merges wdata into the word and sets dirty. PLRU is updated, hit_count increments, and the FSM goes to RESP with hit=1.
  - Miss: miss_count increments. The victim is the lowest-index invalid way; if all ways are valid, the PLRU victim is used. If the victim is valid and dirty, go to EVICT; otherwise go to REFILL_REQ.
- EVICT: o_mem_wb_valid=1; address and line stay stable until i_mem_wb_ready. When ready is seen, go to REFILL_REQ.
- REFILL_REQ: o_mem_rd_valid=1 with the line-aligned request address, held stable until i_mem_rd_ready. When ready is seen, go to REFILL_WAIT.
- REFILL_WAIT: on i_mem_rd_resp_valid, install the line into the victim way with valid=1, dirty=we, and the new tag. For a write, wdata is merged into the installed word. PLRU is updated and the FSM goes to RESP with hit=0.
- RESP: o_resp_valid=1 for exactly one cycle, then IDLE.
- Hit latency: the response pulse appears 2 cycles after the accept edge. Back-to-back hits are accepted every 3 cycles.
- PLRU: binary tree of WAYS-1 bits per set. Node bit 0 points the victim to the left subtree, 1 to the right. Each access sets the bits on its path to point away from the accessed way. Example with WAYS=4 and bits b0 (root), b1 (ways 0/1), b2 (ways 2/3): accessing way0 sets b0=1, b1=1.
- Counters saturate at 0xFFFF_FFFF.
- Inputs i_mem_wb_ready, i_mem_rd_ready and i_mem_rd_resp_valid are ignored outside their own states. i_mem_rd_resp_valid arriving in the same cycle as the accept is ignored.

Test Plan:
- Cold read at 0x0001_0048 (idx 1, tag 4) -> miss; no writeback; o_mem_rd_addr=0x0001_0040. Refill with word k=k -> o_resp_rdata=2, hit=0, miss_count=1.
- Repeat read at 0x0001_0048 -> hit with rdata=2; o_resp_valid exactly 2 cycles after accept; hit_count=1; no memory traffic.
- Write miss 0x0001_0040 with 0xDEADBEEF, then read misses at tags 5, 6, 7 (0x0001_4040, 0x0001_8040, 0x0001_C040), then read 0x0002_0040 -> writeback addr=0x0001_0040, line word0=0xDEADBEEF, issued before the refill request.
- After reset, fill tags 4–7 in set 1, re-read tag 4 (hit), then read tag 8 -> tag 6 (way2) replaced with no writeback. A following tag-4 read hits; a following tag-6 read misses.
- Hold i_mem_wb_ready and i_mem_rd_ready low for 5 cycles each -> valid, address and data stay stable; o_req_ready=0 throughout; exactly one transfer of each.
- Pull rst_n low during REFILL_WAIT -> outputs clear immediately. The next read to the same address misses, and a late i_mem_rd_resp_valid before the new request is ignored.

Source files
------------

// File: rtl/sa_cache_wb_if.sv
// rtl/sa_cache_wb_if.sv - core request/response and line-memory channels of sa_cache_wb
interface sa_cache_wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BYTES = 64
);
    logic                      req_valid;
    logic                      req_ready;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      req_we;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_rdata;
    logic                      resp_hit;
    logic                      mem_rd_valid;
    logic                      mem_rd_ready;
    logic [ADDR_WIDTH-1:0]     mem_rd_addr;
    logic                      mem_rd_resp_valid;
    logic [8*LINE_BYTES-1:0]   mem_rd_line;
    logic                      mem_wb_valid;
    logic                      mem_wb_ready;
    logic [ADDR_WIDTH-1:0]     mem_wb_addr;
    logic [8*LINE_BYTES-1:0]   mem_wb_line;
    logic [31:0]               hit_count;
    logic [31:0]               miss_count;

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        output mem_rd_ready, mem_rd_resp_valid, mem_rd_line, mem_wb_ready,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
        input  mem_rd_valid, mem_rd_addr, mem_wb_valid, mem_wb_addr, mem_wb_line,
        input  hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        input  mem_rd_ready, mem_rd_resp_valid, mem_rd_line, mem_wb_ready,
        output req_ready, resp_valid, resp_rdata, resp_hit,
        output mem_rd_valid, mem_rd_addr, mem_wb_valid, mem_wb_addr, mem_wb_line,
        output hit_count, miss_count
    );
endinterface

// File: rtl/sa_cache_wb.sv
// rtl/sa_cache_wb.sv - N-way set-associative write-back cache with tree PLRU
// Serves one request at a time; dirty victims are written back before the refill is requested.
module sa_cache_wb #(
    parameter int WAYS       = 4,
    parameter int SETS       = 256,
    parameter int LINE_BYTES = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    sa_cache_wb_if.slave bus
);
    localparam int OFF       = $clog2(LINE_BYTES);
    localparam int IDX       = $clog2(SETS);
    localparam int TAG       = ADDR_WIDTH - IDX - OFF;
    localparam int BOFF      = $clog2(DATA_WIDTH / 8);
    localparam int WORDS     = LINE_BYTES * 8 / DATA_WIDTH;
    localparam int LINE_BITS = 8 * LINE_BYTES;
    localparam int LW        = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, REFILL_REQ, REFILL_WAIT, RESP} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   we_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [LW-1:0]          victim_q;

    logic [TAG-1:0]         tag_mem  [WAYS][SETS];
    logic [LINE_BITS-1:0]   data_mem [WAYS][SETS];
    logic [WAYS-1:0]        valid_q  [SETS];
    logic [WAYS-1:0]        dirty_q  [SETS];
    logic [WAYS-2:0]        plru_q   [SETS];

    logic                   req_ready_q, resp_valid_q, resp_hit_q;
    logic [DATA_WIDTH-1:0]  resp_rdata_q;
    logic                   rd_valid_q, wb_valid_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, wb_addr_q;
    logic [LINE_BITS-1:0]   wb_line_q;
    logic [31:0]            hit_cnt, miss_cnt;

    logic [TAG-1:0]         req_tag;
    logic [IDX-1:0]         req_idx;
    logic [ADDR_WIDTH-1:0]  line_addr;
    int                     word_idx;
    logic                   hit;
    logic [LW-1:0]          hit_way, victim, touch_way;
    logic                   inv_found;
    logic [WAYS-2:0]        plru_next;
    logic [LINE_BITS-1:0]   hit_line;
    logic [DATA_WIDTH-1:0]  hit_word, refill_word;
    logic                   arr_we;
    logic [LW-1:0]          arr_way;
    logic [LINE_BITS-1:0]   arr_line;

    function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int            node;
        logic [LW-1:0] way;
        node = 0;
        way  = '0;
        for (int l = 0; l < LW; l++) begin
            way  = (way << 1) | LW'(bits[node]);
            node = 2 * node + 1 + int'(bits[node]);
        end
        return way;
    endfunction

    // Every node on the accessed way's path is pointed at the opposite subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits, input logic [LW-1:0] way);
        logic [WAYS-2:0] nb;
        int              node;
        logic            b;
        nb   = bits;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            b        = way[LW-1-l];
            nb[node] = ~b;
            node     = 2 * node + 1 + int'(b);
        end
        return nb;
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line, input int w,
                                                        input logic [DATA_WIDTH-1:0] d);
        logic [LINE_BITS-1:0] m;
        m = line;
        m[w*DATA_WIDTH +: DATA_WIDTH] = d;
        return m;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign req_tag   = addr_q[ADDR_WIDTH-1 -: TAG];
    assign req_idx   = addr_q[OFF+IDX-1 : OFF];
    assign line_addr = {req_tag, req_idx, {OFF{1'b0}}};
    assign word_idx  = int'((addr_q >> BOFF) & ADDR_WIDTH'(WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = LW'(w);
            end
        end
    end

    // Empty ways are filled lowest-first; PLRU only chooses once the set is full.
    always_comb begin
        inv_found = 1'b0;
        victim    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                victim    = LW'(w);
            end
        end
        if (!inv_found) victim = plru_victim(plru_q[req_idx]);
    end

    assign touch_way   = (state == REFILL_WAIT) ? victim_q : hit_way;
    assign plru_next   = plru_touch(plru_q[req_idx], touch_way);
    assign hit_line    = data_mem[hit_way][req_idx];
    assign hit_word    = hit_line[word_idx*DATA_WIDTH +: DATA_WIDTH];
    assign refill_word = bus.mem_rd_line[word_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        arr_we   = 1'b0;
        arr_way  = hit_way;
        arr_line = hit_line;
        if (state == LOOKUP && hit && we_q) begin
            arr_we   = 1'b1;
            arr_line = merge_word(hit_line, word_idx, wdata_q);
        end else if (state == REFILL_WAIT && bus.mem_rd_resp_valid) begin
            arr_we   = 1'b1;
            arr_way  = victim_q;
            arr_line = we_q ? merge_word(bus.mem_rd_line, word_idx, wdata_q) : bus.mem_rd_line;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_mem[arr_way][req_idx] <= arr_line;
            tag_mem[arr_way][req_idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            victim_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_line_q    <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        we_q        <= bus.req_we;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (we_q) dirty_q[req_idx][hit_way] <= 1'b1;
                        plru_q[req_idx] <= plru_next;
                        resp_rdata_q    <= we_q ? wdata_q : hit_word;
                        resp_hit_q      <= 1'b1;
                        resp_valid_q    <= 1'b1;
                        hit_cnt         <= sat_inc(hit_cnt);
                        state           <= RESP;
                    end else begin
                        miss_cnt <= sat_inc(miss_cnt);
                        victim_q <= victim;
                        if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            wb_valid_q <= 1'b1;
                            wb_addr_q  <= {tag_mem[victim][req_idx], req_idx, {OFF{1'b0}}};
                            wb_line_q  <= data_mem[victim][req_idx];
                            state      <= EVICT;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= line_addr;
                            state      <= REFILL_REQ;
                        end
                    end
                end
                EVICT: begin
                    if (bus.mem_wb_ready) begin
                        wb_valid_q <= 1'b0;
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= line_addr;
                        state      <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state      <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_rd_resp_valid) begin
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= we_q;
                        plru_q[req_idx]            <= plru_next;
                        resp_rdata_q               <= we_q ? wdata_q : refill_word;
                        resp_hit_q                 <= 1'b0;
                        resp_valid_q               <= 1'b1;
                        state                      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_hit_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.mem_rd_valid = rd_valid_q;
    assign bus.mem_rd_addr  = rd_addr_q;
    assign bus.mem_wb_valid = wb_valid_q;
    assign bus.mem_wb_addr  = wb_addr_q;
    assign bus.mem_wb_line  = wb_line_q;
    assign bus.hit_count    = hit_cnt;
    assign bus.miss_count   = miss_cnt;
endmodule

// File: tb/tb_sa_cache_wb.sv
// tb/tb_sa_cache_wb.sv - directed bench for sa_cache_wb
// Acts as core and line memory; refill line word k holds line_base + k.
module tb_sa_cache_wb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_cache_wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_BYTES(64)) bus ();

    sa_cache_wb #(.WAYS(4), .SETS(256), .LINE_BYTES(64), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]  line_base;
    logic [31:0]  r_data;
    logic         r_hit;
    int           lat, n_wb, n_rd, wb_done_at_rd;
    logic [31:0]  wb_addr_s, wb_w0, wb_w1, rd_addr_s;
    logic         stable_ok, ready_low_ok, got_resp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One core request, serviced by an always-willing memory after the given stall counts.
    task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input int wb_stall, input int rd_stall);
        int  wb_seen, rd_seen, cyc, guard;
        bit  send_resp;
        logic [31:0]  wb_a0, rd_a0;
        logic [511:0] wb_l0;
        wb_seen = 0; rd_seen = 0; n_wb = 0; n_rd = 0; wb_done_at_rd = -1;
        stable_ok = 1'b1; ready_low_ok = 1'b1; got_resp = 1'b0; send_resp = 1'b0;
        wb_a0 = '0; rd_a0 = '0; wb_l0 = '0; lat = -1;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_we = we; bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (bus.mem_wb_ready) bus.mem_wb_ready = 1'b0;
            if (bus.mem_rd_resp_valid) bus.mem_rd_resp_valid = 1'b0;
            if (bus.mem_rd_ready) begin
                bus.mem_rd_ready = 1'b0;
                send_resp = 1'b1;
            end
            if (bus.resp_valid) begin
                r_data = bus.resp_rdata; r_hit = bus.resp_hit; lat = cyc; got_resp = 1'b1;
                break;
            end
            if (bus.req_ready) ready_low_ok = 1'b0;
            if (bus.mem_wb_valid) begin
                if (wb_seen == 0) begin
                    wb_a0 = bus.mem_wb_addr; wb_l0 = bus.mem_wb_line;
                    wb_addr_s = wb_a0; wb_w0 = wb_l0[31:0]; wb_w1 = wb_l0[63:32];
                end else if (bus.mem_wb_addr !== wb_a0 || bus.mem_wb_line !== wb_l0) stable_ok = 1'b0;
                wb_seen++;
                if (wb_seen > wb_stall) begin
                    bus.mem_wb_ready = 1'b1;
                    n_wb++;
                end
            end
            if (bus.mem_rd_valid) begin
                if (rd_seen == 0) begin
                    rd_a0 = bus.mem_rd_addr; rd_addr_s = rd_a0; wb_done_at_rd = n_wb;
                end else if (bus.mem_rd_addr !== rd_a0) stable_ok = 1'b0;
                rd_seen++;
                if (rd_seen > rd_stall) begin
                    bus.mem_rd_ready = 1'b1;
                    n_rd++;
                end
            end
            if (send_resp) begin
                bus.mem_rd_line = make_line(line_base);
                bus.mem_rd_resp_valid = 1'b1;
                send_resp = 1'b0;
            end
            @(negedge clk);
        end
        bus.mem_wb_ready = 1'b0; bus.mem_rd_ready = 1'b0; bus.mem_rd_resp_valid = 1'b0;
        check("resp_timeout", 64'(got_resp), 64'd1);
    endtask

    initial begin
        int guard;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_wdata = '0;
        bus.mem_rd_ready = 1'b0; bus.mem_rd_resp_valid = 1'b0; bus.mem_rd_line = '0;
        bus.mem_wb_ready = 1'b0;
        line_base = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_req_ready",  64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_rd_valid",   64'(bus.mem_rd_valid), 64'd0);
        check("rst_wb_valid",   64'(bus.mem_wb_valid), 64'd0);
        check("rst_hits",       64'(bus.hit_count), 64'd0);
        check("rst_misses",     64'(bus.miss_count), 64'd0);

        // Cold read miss, then the same word hits with no memory traffic.
        line_base = 32'd0;
        access(32'h0001_0048, 1'b0, '0, 0, 0);
        check("cold_rdata",  64'(r_data), 64'd2);
        check("cold_hit",    64'(r_hit), 64'd0);
        check("cold_nwb",    64'(n_wb), 64'd0);
        check("cold_nrd",    64'(n_rd), 64'd1);
        check("cold_rdaddr", 64'(rd_addr_s), 64'h0001_0040);
        check("cold_misses", 64'(bus.miss_count), 64'd1);
        access(32'h0001_0048, 1'b0, '0, 0, 0);
        check("hit_rdata",   64'(r_data), 64'd2);
        check("hit_hit",     64'(r_hit), 64'd1);
        check("hit_latency", 64'(lat), 64'd2);
        check("hit_count",   64'(bus.hit_count), 64'd1);
        check("hit_nrd",     64'(n_rd + n_wb), 64'd0);

        // Dirty line evicted by PLRU after filling the set; memory stalls both channels.
        do_reset();
        line_base = 32'h100;
        access(32'h0001_0040, 1'b1, 32'hDEAD_BEEF, 0, 0);
        check("wmiss_echo", 64'(r_data), 64'hDEAD_BEEF);
        check("wmiss_hit",  64'(r_hit), 64'd0);
        line_base = 32'h500; access(32'h0001_4040, 1'b0, '0, 0, 0);
        line_base = 32'h600; access(32'h0001_8040, 1'b0, '0, 0, 0);
        line_base = 32'h700; access(32'h0001_C040, 1'b0, '0, 0, 0);
        check("fill_nwb", 64'(n_wb), 64'd0);
        line_base = 32'h800;
        access(32'h0002_0040, 1'b0, '0, 5, 5);
        check("wb_addr",      64'(wb_addr_s), 64'h0001_0040);
        check("wb_word0",     64'(wb_w0), 64'hDEAD_BEEF);
        check("wb_word1",     64'(wb_w1), 64'h101);
        check("wb_count",     64'(n_wb), 64'd1);
        check("wb_then_rd",   64'(wb_done_at_rd), 64'd1);
        check("rd_count",     64'(n_rd), 64'd1);
        check("rd_addr",      64'(rd_addr_s), 64'h0002_0040);
        check("stall_stable", 64'(stable_ok), 64'd1);
        check("stall_ready0", 64'(ready_low_ok), 64'd1);
        check("evict_rdata",  64'(r_data), 64'h800);
        check("evict_misses", 64'(bus.miss_count), 64'd5);

        // Clean PLRU replacement: tag 6 (way 2) is the victim after re-touching tag 4.
        do_reset();
        line_base = 32'h400; access(32'h0001_0048, 1'b0, '0, 0, 0);
        line_base = 32'h500; access(32'h0001_4048, 1'b0, '0, 0, 0);
        line_base = 32'h600; access(32'h0001_8048, 1'b0, '0, 0, 0);
        line_base = 32'h700; access(32'h0001_C048, 1'b0, '0, 0, 0);
        access(32'h0001_0048, 1'b0, '0, 0, 0);
        check("plru_t4_hit",   64'(r_hit), 64'd1);
        check("plru_t4_data",  64'(r_data), 64'h402);
        line_base = 32'h880; access(32'h0002_0048, 1'b0, '0, 0, 0);
        check("plru_t8_hit",   64'(r_hit), 64'd0);
        check("plru_t8_nwb",   64'(n_wb), 64'd0);
        check("plru_t8_data",  64'(r_data), 64'h882);
        access(32'h0001_0048, 1'b0, '0, 0, 0);
        check("plru_t4_again", 64'(r_hit), 64'd1);
        line_base = 32'h660; access(32'h0001_8048, 1'b0, '0, 0, 0);
        check("plru_t6_miss",  64'(r_hit), 64'd0);
        check("plru_t6_data",  64'(r_data), 64'h662);
        check("plru_hits",     64'(bus.hit_count), 64'd2);
        check("plru_misses",   64'(bus.miss_count), 64'd6);

        // Reset during REFILL_WAIT aborts the refill; a stale response afterwards is ignored.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h0003_0048; bus.req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.mem_rd_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("abort_rd_seen", 64'(bus.mem_rd_valid), 64'd1);
        bus.mem_rd_ready = 1'b1;
        @(negedge clk);
        bus.mem_rd_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_rd_valid",   64'(bus.mem_rd_valid), 64'd0);
        check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("abort_req_ready",  64'(bus.req_ready), 64'd1);
        check("abort_misses",     64'(bus.miss_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rd_line = make_line(32'hBAD0);
        bus.mem_rd_resp_valid = 1'b1;
        @(negedge clk);
        bus.mem_rd_resp_valid = 1'b0;
        check("late_no_resp", 64'(bus.resp_valid), 64'd0);
        line_base = 32'h300;
        access(32'h0003_0048, 1'b0, '0, 0, 0);
        check("after_abort_hit",    64'(r_hit), 64'd0);
        check("after_abort_nrd",    64'(n_rd), 64'd1);
        check("after_abort_rdata",  64'(r_data), 64'h302);
        check("after_abort_misses", 64'(bus.miss_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
